// File: rtl/grf_wb_queue.sv
// Writeback queue in front of the GRF write port: in-order drain, one write per
// cycle, with youngest-value lookup so GRF readers can forward queued data.

module grf_wb_lookup #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic [DEPTH-1:0][4:0]  ent_a3,
    input  logic [DEPTH-1:0][31:0] ent_wd,
    input  logic [DEPTH-1:0]       ent_vld,
    input  logic [PTR_W-1:0]       rd_ptr,
    input  logic [4:0]             q_a,
    output logic                   hit,
    output logic [31:0]            data
);
    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest; valid entries are contiguous from rd_ptr, so the
    // last match seen is the youngest pending write.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((q_a != 5'd0) && ent_vld[idx] && (ent_a3[idx] == q_a)) begin
                hit  = 1'b1;
                data = ent_wd[idx];
            end
        end
    end
endmodule

module grf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_a3,
    input  logic [31:0]      in_wd,
    input  logic [31:0]      in_pc,
    input  logic             wb_hold,
    output logic             WE,
    output logic [4:0]       A3,
    output logic [31:0]      WD,
    output logic [31:0]      WPC,
    input  logic [4:0]       q1_a,
    output logic             q1_hit,
    output logic [31:0]      q1_data,
    input  logic [4:0]       q2_a,
    output logic             q2_hit,
    output logic [31:0]      q2_data,
    output logic [PTR_W:0]   count
);
    localparam int NUM_LK = 2;
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [PTR_W:0]         cnt;
    logic [DEPTH-1:0]       vld;
    logic [DEPTH-1:0][4:0]  a3_q;
    logic [DEPTH-1:0][31:0] wd_q;
    logic [DEPTH-1:0][31:0] pc_q;

    logic has_head, pop, push_acc, push_wr;

    assign has_head = (cnt != '0);
    assign in_ready = (cnt < FULL_CNT);
    assign WE       = has_head && !wb_hold;
    assign pop      = WE;
    assign push_acc = in_valid && in_ready;
    // Writes to $0 complete the handshake but are dropped.
    assign push_wr  = push_acc && (in_a3 != 5'd0);

    assign A3    = has_head ? a3_q[rd_ptr] : '0;
    assign WD    = has_head ? wd_q[rd_ptr] : '0;
    assign WPC   = has_head ? pc_q[rd_ptr] : '0;
    assign count = cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            vld    <= '0;
        end else begin
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                vld[rd_ptr] <= 1'b0;
            end
            if (push_wr) begin
                wr_ptr      <= wr_ptr + 1'b1;
                vld[wr_ptr] <= 1'b1;
            end
            case ({push_wr, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset: vld/cnt gate every use of it.
    always_ff @(posedge Clk) begin
        if (push_wr) begin
            a3_q[wr_ptr] <= in_a3;
            wd_q[wr_ptr] <= in_wd;
            pc_q[wr_ptr] <= in_pc;
        end
    end

    logic [NUM_LK-1:0][4:0]  lk_a;
    logic [NUM_LK-1:0]       lk_hit;
    logic [NUM_LK-1:0][31:0] lk_data;

    assign lk_a = {q2_a, q1_a};

    for (genvar p = 0; p < NUM_LK; p++) begin : g_lk
        grf_wb_lookup #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_lk (
            .ent_a3  (a3_q),
            .ent_wd  (wd_q),
            .ent_vld (vld),
            .rd_ptr  (rd_ptr),
            .q_a     (lk_a[p]),
            .hit     (lk_hit[p]),
            .data    (lk_data[p])
        );
    end

    assign q1_hit  = lk_hit[0];
    assign q1_data = lk_data[0];
    assign q2_hit  = lk_hit[1];
    assign q2_data = lk_data[1];
endmodule

// File: tb/tb_grf_wb_queue.sv
// Directed bench for grf_wb_queue: queue-based reference model compared every
// cycle, plus literal expectations at key points.

module tb_grf_wb_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_a3;
    logic [31:0] in_wd;
    logic [31:0] in_pc;
    logic        wb_hold;
    logic        WE;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] WPC;
    logic [4:0]  q1_a;
    logic        q1_hit;
    logic [31:0] q1_data;
    logic [4:0]  q2_a;
    logic        q2_hit;
    logic [31:0] q2_data;
    logic [PTR_W:0] count;

    int total = 0;
    int bad   = 0;

    grf_wb_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a3(in_a3), .in_wd(in_wd), .in_pc(in_pc),
        .wb_hold(wb_hold),
        .WE(WE), .A3(A3), .WD(WD), .WPC(WPC),
        .q1_a(q1_a), .q1_hit(q1_hit), .q1_data(q1_data),
        .q2_a(q2_a), .q2_hit(q2_hit), .q2_data(q2_data),
        .count(count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t mq[$];

    // Reference model: a plain FIFO of pending writes.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mq.delete();
        end else begin
            automatic bit do_pop  = (mq.size() != 0) && !wb_hold;
            automatic bit do_push = in_valid && (mq.size() < DEPTH) && (in_a3 != 5'd0);
            automatic ent_t e;
            e.a3 = in_a3; e.wd = in_wd; e.pc = in_pc;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_look(input logic [4:0] a, output logic hit, output logic [31:0] data);
        hit = 1'b0;
        data = '0;
        if (a != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].a3 == a) begin
                    hit = 1'b1;
                    data = mq[i].wd;
                    break;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic        h1, h2;
        logic [31:0] d1, d2;
        bit          nonempty;
        nonempty = (mq.size() != 0);
        model_look(q1_a, h1, d1);
        model_look(q2_a, h2, d2);
        chk("m_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("m_count",    32'(count),    32'(mq.size()));
        chk("m_WE",       32'(WE),       32'(nonempty && !wb_hold));
        chk("m_A3",       32'(A3),       nonempty ? 32'(mq[0].a3) : 32'd0);
        chk("m_WD",       WD,            nonempty ? mq[0].wd : 32'd0);
        chk("m_WPC",      WPC,           nonempty ? mq[0].pc : 32'd0);
        chk("m_q1_hit",   32'(q1_hit),   32'(h1));
        chk("m_q1_data",  q1_data,       d1);
        chk("m_q2_hit",   32'(q2_hit),   32'(h2));
        chk("m_q2_data",  q2_data,       d2);
    endtask

    // One cycle: compare on the falling edge, then step past the rising edge.
    task automatic cyc();
        @(negedge Clk);
        compare_all();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p);
        in_valid = 1'b1; in_a3 = a; in_wd = d; in_pc = p;
        cyc();
        in_valid = 1'b0; in_a3 = '0; in_wd = '0; in_pc = '0;
    endtask

    initial begin
        Reset = 1'b0; in_valid = 1'b0; in_a3 = '0; in_wd = '0; in_pc = '0;
        wb_hold = 1'b0; q1_a = '0; q2_a = '0;
        #12;
        chk("rst_WE", 32'(WE), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_q1_hit", 32'(q1_hit), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b1;
        cyc(); cyc();
        chk("idle_WE", 32'(WE), 32'd0);

        // Single write, no hold
        push(5'd5, 32'h1234, 32'h3000);
        chk("one_WE", 32'(WE), 32'd1);
        chk("one_A3", 32'(A3), 32'd5);
        chk("one_WD", WD, 32'h1234);
        chk("one_WPC", WPC, 32'h3000);
        cyc();
        chk("one_count_after", 32'(count), 32'd0);
        chk("one_WE_after", 32'(WE), 32'd0);

        // Fill while held, overflow push refused, then drain in order
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i), 32'h4000 + 32'(4 * i));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd4);
        push(5'd9, 32'h999, 32'h4100);
        chk("full_count_after5", 32'(count), 32'd4);
        wb_hold = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_A3", 32'(A3), 32'(i));
            cyc();
            if (i == 1) chk("drain_ready_after_pop", 32'(in_ready), 32'd1);
        end
        chk("drain_count", 32'(count), 32'd0);

        // Same register twice: lookup returns youngest, GRF sees oldest first
        wb_hold = 1'b1;
        push(5'd7, 32'hA, 32'h5000);
        push(5'd7, 32'hB, 32'h5004);
        q1_a = 5'd7; q2_a = 5'd0;
        #1;
        chk("lk_q1_hit", 32'(q1_hit), 32'd1);
        chk("lk_q1_data", q1_data, 32'hB);
        chk("lk_q2_hit", 32'(q2_hit), 32'd0);
        wb_hold = 1'b0;
        #1;
        chk("dup_first_WD", WD, 32'hA);
        cyc();
        chk("dup_second_WD", WD, 32'hB);
        chk("dup_q1_data_mid", q1_data, 32'hB);
        cyc();
        chk("dup_q1_hit_after", 32'(q1_hit), 32'd0);

        // $0 write: accepted but dropped
        chk("r0_in_ready", 32'(in_ready), 32'd1);
        push(5'd0, 32'hDEAD, 32'h6000);
        chk("r0_count", 32'(count), 32'd0);
        chk("r0_WE", 32'(WE), 32'd0);
        cyc();

        // Full with a pop on the same edge: push still refused
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(12 + i), 32'h200 + 32'(i), 32'h7000 + 32'(4 * i));
        wb_hold = 1'b0;
        push(5'd20, 32'h2020, 32'h7100);
        chk("fullpop_count", 32'(count), 32'd3);
        chk("fullpop_A3", 32'(A3), 32'd13);
        q2_a = 5'd20;
        #1;
        chk("fullpop_q2_hit", 32'(q2_hit), 32'd0);
        for (int i = 0; i < 4; i++) cyc();

        // Mixed traffic: simultaneous push/pop, $0 pushes, hold toggling
        q1_a = 5'd3; q2_a = 5'd1;
        for (int i = 0; i < 12; i++) begin
            wb_hold = (i % 3 == 2);
            push(5'(i % 4), 32'h300 + 32'(i), 32'h8000 + 32'(4 * i));
        end
        wb_hold = 1'b0;
        for (int i = 0; i < 6; i++) cyc();

        // Asynchronous reset with writes queued
        wb_hold = 1'b1; q1_a = 5'd11;
        push(5'd10, 32'h410, 32'h9000);
        push(5'd11, 32'h411, 32'h9004);
        push(5'd12, 32'h412, 32'h9008);
        wb_hold = 1'b0;
        #1;
        chk("prerst_WE", 32'(WE), 32'd1);
        chk("prerst_count", 32'(count), 32'd3);
        chk("prerst_q1_hit", 32'(q1_hit), 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        chk("arst_WE", 32'(WE), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_q1_hit", 32'(q1_hit), 32'd0);
        chk("arst_A3", 32'(A3), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        cyc(); cyc();
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("postrst_WE", 32'(WE), 32'd0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
